spi_cfg_master: RTL and testbench
=================================

Name: spi_cfg_master

Overview:
SPI controller that sequences register-write frames into the chip's SPI configuration peripheral, which holds the output-enable, PWM-enable and duty-cycle registers. It arbitrates round-robin between NREQ on-chip requesters. Each accepted request becomes one 16-bit mode-0 write frame on nCS/SCLK/COPI. It sits between internal control logic and the peripheral's SPI pins, in the same clk domain as the peripheral.

Parameters:
NREQ, 2, number of requesters (1..8)
CLK_DIV, 4, clk cycles per SCLK half-period; must be >= 4 so the peripheral's 2-flop synchronisers see every edge; elaboration error if < 4
CS_GAP, 4, minimum clk cycles nCS stays high between frames; must be >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester write request, level, held until gnt
req_addr  in  7*NREQ  register address, requester i at [7i+6:7i]
req_data  in  8*NREQ  write data, requester i at [8i+7:8i]
gnt  out  NREQ  one-cycle pulse; request accepted, addr/data captured
done  out  NREQ  one-cycle pulse to the granted requester when its frame completes
busy  out  1  high from grant until the end of the GAP state
nCS  out  1  SPI chip select, active low
SCLK  out  1  SPI clock, idles low
COPI  out  1  SPI data out

Behaviour:
- Reset values: nCS=1, SCLK=0, COPI=0, gnt=0, done=0, busy=0, round-robin pointer=0, FSM=IDLE. Outputs take these values immediately on assertion, with no clock required.
- Frame format, MSB first: bit15=1 (write), bits14:8=addr, bits7:0=data. Example: addr 0x04, data 0xA5 gives 0x84A5.
- Mode 0: COPI changes only while SCLK is low. The peripheral samples on the SCLK rising edge.
- FSM states: IDLE, SETUP, SHIFT, GAP.
- IDLE: when any req is high, pick the winner round-robin. The search starts at (last granted index + 1) mod NREQ; after reset it starts at index 0.
- On the next edge: gnt[winner] pulses for 1 cycle, addr/data are latched into the shift register, nCS=0, COPI=bit15, busy=1, go to SETUP.
- SETUP: hold SCLK low for CLK_DIV cycles, then go to SHIFT.
- SHIFT: each of 16 bits is CLK_DIV cycles SCLK high, then CLK_DIV cycles SCLK low. The next bit is driven on the cycle SCLK falls.
- After bit 0's low half, nCS=1, COPI=0, done[winner] pulses for 1 cycle, go to GAP.
- nCS is low for exactly 33*CLK_DIV cycles. There are exactly 16 SCLK rising edges per frame.
- GAP: nCS high for CS_GAP cycles, then busy=0 and go to IDLE. Arbitration in IDLE happens in the same cycle, so the next nCS falling edge comes at least CS_GAP+1 cycles after the previous rising edge.
- req asserted while busy stays pending and is arbitrated in the next IDLE. If req is still high in the cycle after its gnt, that is treated as a new request.
- Latched addr/data are immune to input changes after gnt.
- Simultaneous requests: exactly one gnt per frame. The last-granted requester gets lowest priority next round.
- NREQ=1: the pointer is unused and the block is a simple sequencer.
- Reset mid-frame aborts the frame: nCS rises immediately and no done is issued. The peripheral restarts its bit count on the next nCS falling edge.
- Address is not range-checked. Addresses > 0x04 are sent and the peripheral ignores them.

Optional Feature:
SPI_CFG_SHADOW_EN:
- When defined: adds output port shadow [39:0], mirrors of addresses 0x00..0x04 at [8a+7:8a], reset to 0 to match the peripheral.
- shadow updates on done for addresses 0..4.
- A granted request to address 0..4 whose data equals the shadow value issues no frame. gnt pulses, done pulses the following cycle, busy stays low, nCS never falls.
- Addresses > 4 are always sent.
- When undefined: no shadow port, and every request produces a frame.

Test Plan:
- CLK_DIV=4, req[0] with addr 0x04, data 0xA5 -> gnt[0] one pulse; nCS low 132 cycles; 16 SCLK rises sampling 1000_0100_1010_0101; done[0] pulses on the nCS-rise cycle.
- req=2'b11 held, then re-asserted after each gnt, for 4 frames -> grant order 0,1,0,1; never two gnts in one frame; nCS high >= CS_GAP cycles between frames.
- Spec-compliant peripheral model attached; write 0x02<-0x3C, then 0x00<-0xFF -> peripheral en_reg_pwm_7_0=0x3C and en_reg_out_7_0=0xFF, all other registers 0.
- rst_n pulsed low after the 5th SCLK rise -> nCS=1, SCLK=0, no done; a following write 0x01<-0x81 lands intact in peripheral en_reg_out_15_8.
- req_data changes in the cycle after gnt -> frame carries the originally latched data.
- SPI_CFG_SHADOW_EN defined: write 0x04<-0x10 twice -> first makes a frame and shadow[39:32]=0x10; second gives gnt+done with no nCS falling edge. Addr 0x05 is always framed.

Source files
------------

// File: rtl/spi_cfg_master.sv
// Round-robin SPI mode-0 write sequencer for the configuration peripheral (16-bit frames).
// Optional macro SPI_CFG_SHADOW_EN adds a register shadow that suppresses redundant writes.
module spi_cfg_master #(
  parameter int NREQ    = 2,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              nCS,
  output logic              SCLK,
  output logic              COPI
`ifdef SPI_CFG_SHADOW_EN
  , output logic [39:0]     shadow
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(CS_GAP + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  // The peripheral's 2-flop synchronisers need at least 4 clk per SCLK half-period.
  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("spi_cfg_master: CLK_DIV must be >= 4");
  end
  if (CS_GAP < 2) begin : g_bad_cs_gap
    $error("spi_cfg_master: CS_GAP must be >= 2");
  end
  if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
    $error("spi_cfg_master: NREQ must be 1..8");
  end

  logic [1:0]      state_reg;
  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   owner_reg;
  logic [14:0]     shift_reg;
  logic [DW-1:0]   div_cnt_reg;
  logic [3:0]      bit_cnt_reg;
  logic [GW-1:0]   gap_cnt_reg;
  logic            ncs_reg, sclk_reg, copi_reg, busy_reg, skip_reg;
  logic [NREQ-1:0] gnt_reg, done_reg;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [6:0]      sel_addr;
  logic [7:0]      sel_data;
  logic            shadow_hit;
  logic            div_last, frame_end;

  // Smallest requester at or above the pointer wins, else wrap to the smallest below it.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && IW'(i) < ptr_reg) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && IW'(i) >= ptr_reg) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        sel_addr = req_addr[7*i +: 7];
        sel_data = req_data[8*i +: 8];
      end
    end
  end

  assign div_last  = (div_cnt_reg == DW'(CLK_DIV - 1));
  assign frame_end = (state_reg == SHIFT) && div_last && !sclk_reg && (bit_cnt_reg == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      owner_reg   <= '0;
      shift_reg   <= '0;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      ncs_reg     <= 1'b1;
      sclk_reg    <= 1'b0;
      copi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      skip_reg    <= 1'b0;
      gnt_reg     <= '0;
      done_reg    <= '0;
    end else begin
      gnt_reg  <= '0;
      done_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (skip_reg) begin
            skip_reg <= 1'b0;
            done_reg <= NREQ'(1) << owner_reg;
          end else if (win_found) begin
            gnt_reg   <= NREQ'(1) << win_idx;
            owner_reg <= win_idx;
            ptr_reg   <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            if (shadow_hit) begin
              skip_reg <= 1'b1;
            end else begin
              state_reg   <= SETUP;
              ncs_reg     <= 1'b0;
              copi_reg    <= 1'b1;
              shift_reg   <= {sel_addr, sel_data};
              busy_reg    <= 1'b1;
              div_cnt_reg <= '0;
            end
          end
        end
        SETUP: begin
          if (div_last) begin
            state_reg   <= SHIFT;
            sclk_reg    <= 1'b1;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        SHIFT: begin
          if (div_last) begin
            div_cnt_reg <= '0;
            if (sclk_reg) begin
              sclk_reg  <= 1'b0;
              copi_reg  <= shift_reg[14];
              shift_reg <= {shift_reg[13:0], 1'b0};
            end else if (frame_end) begin
              ncs_reg     <= 1'b1;
              copi_reg    <= 1'b0;
              done_reg    <= NREQ'(1) << owner_reg;
              gap_cnt_reg <= '0;
              state_reg   <= GAP;
            end else begin
              sclk_reg    <= 1'b1;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        default: begin
          if (gap_cnt_reg == GW'(CS_GAP - 1)) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef SPI_CFG_SHADOW_EN
  logic [39:0] shadow_reg;
  logic [6:0]  addr_reg;
  logic [7:0]  data_reg;

  always_comb begin
    shadow_hit = 1'b0;
    for (int a = 0; a < 5; a++) begin
      if (sel_addr == 7'(a) && sel_data == shadow_reg[8*a +: 8]) shadow_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
    end else begin
      if (state_reg == IDLE && !skip_reg && win_found) begin
        addr_reg <= sel_addr;
        data_reg <= sel_data;
      end
      if (frame_end) begin
        for (int a = 0; a < 5; a++) begin
          if (addr_reg == 7'(a)) shadow_reg[8*a +: 8] <= data_reg;
        end
      end
    end
  end

  assign shadow = shadow_reg;
`else
  assign shadow_hit = 1'b0;
`endif

  assign gnt  = gnt_reg;
  assign done = done_reg;
  assign busy = busy_reg;
  assign nCS  = ncs_reg;
  assign SCLK = sclk_reg;
  assign COPI = copi_reg;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master with a clk-sampled SPI peripheral model.
module tb_spi_cfg_master;
  localparam int NREQ = 2;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [7*NREQ-1:0] req_addr = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0] gnt, done;
  logic busy, nCS, SCLK, COPI;
`ifdef SPI_CFG_SHADOW_EN
  logic [39:0] shadow;
`endif

  spi_cfg_master #(.NREQ(NREQ), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .done(done), .busy(busy), .nCS(nCS), .SCLK(SCLK), .COPI(COPI)
`ifdef SPI_CFG_SHADOW_EN
    , .shadow(shadow)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Peripheral model and protocol monitor, sampled on the rising clk edge.
  logic periph_clr = 1'b0;
  logic [7:0] preg [0:4] = '{default: 8'h00};
  logic p_ncs = 1'b1, p_sclk = 1'b0;
  logic [15:0] sr = '0, last_word = '0;
  int mon_frames = 0, mon_gnts = 0, mon_dones = 0, mon_multi = 0;
  int low_len = 0, last_low = 0, rises = 0, last_rises = 0, high_len = 0, last_high = 0;

  always @(posedge clk) begin
    if (periph_clr) for (int a = 0; a < 5; a++) preg[a] = 8'h00;
    if ($countones(gnt) > 1) mon_multi++;
    if (gnt != '0) mon_gnts++;
    if (done != '0) mon_dones++;
    if (!nCS) begin
      if (p_ncs) begin
        mon_frames++; last_high = high_len; low_len = 1; rises = 0;
      end else low_len++;
      if (SCLK && !p_sclk) begin
        sr = {sr[14:0], COPI}; rises++;
      end
    end else begin
      if (!p_ncs) begin
        last_low = low_len; last_rises = rises; last_word = sr; high_len = 1;
        if (rises == 16 && sr[15] && sr[14:8] <= 7'd4) preg[sr[10:8]] = sr[7:0];
      end else high_len++;
    end
    p_ncs = nCS;
    p_sclk = SCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic g_busy, g_ncs, g_copi, g_sclk, d_ncs, d_busy;
  int busy_wait;

  task automatic do_write(input int idx, input logic [6:0] a, input logic [7:0] d,
                          input logic mangle);
    int c;
    logic [NREQ-1:0] exp_g;
    exp_g = '0;
    exp_g[idx] = 1'b1;
    @(negedge clk);
    req_addr[idx*7 +: 7] = a;
    req_data[idx*8 +: 8] = d;
    req[idx] = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!gnt[idx] && c < 60);
    chk($sformatf("gnt%0d", idx), 32'(gnt), 32'(exp_g));
    g_busy = busy; g_ncs = nCS; g_copi = COPI; g_sclk = SCLK;
    req[idx] = 1'b0;
    if (mangle) begin
      req_addr[idx*7 +: 7] = 7'h00;
      req_data[idx*8 +: 8] = ~d;
    end
    @(negedge clk);
    chk("gnt_one_pulse", 32'(gnt), 32'h0);
    c = 0;
    while (!done[idx] && c < 400) begin @(negedge clk); c++; end
    chk($sformatf("done%0d", idx), 32'(done), 32'(exp_g));
    d_ncs = nCS; d_busy = busy;
    c = 0;
    while (busy && c < 40) begin @(negedge clk); c++; end
    busy_wait = c;
    chk("back_to_idle", 32'(busy), 32'h0);
    $display("write req%0d addr=0x%02h data=0x%02h word=0x%04h", idx, a, d, last_word);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int c, r, idx, f0, g0, d0, min_gap;
  logic prev_sclk;
  logic [NREQ-1:0] exp_rr;

  initial begin
    // Asynchronous reset: outputs settle with no clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ncs", 32'(nCS), 32'h1);
    chk("rst_sclk", 32'(SCLK), 32'h0);
    chk("rst_copi", 32'(COPI), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single frame 0x04 <- 0xA5.
    do_write(0, 7'h04, 8'hA5, 1'b0);
    chk("t1_busy_at_gnt", 32'(g_busy), 32'h1);
    chk("t1_ncs_at_gnt", 32'(g_ncs), 32'h0);
    chk("t1_copi_bit15", 32'(g_copi), 32'h1);
    chk("t1_sclk_at_gnt", 32'(g_sclk), 32'h0);
    chk("t1_ncs_at_done", 32'(d_ncs), 32'h1);
    chk("t1_busy_at_done", 32'(d_busy), 32'h1);
    chk("t1_gap_cycles", 32'(busy_wait), 32'(CS_GAP));
    chk("t1_ncs_low_len", 32'(last_low), 32'(33 * CLK_DIV));
    chk("t1_sclk_rises", 32'(last_rises), 32'd16);
    chk("t1_word", 32'(last_word), 32'h84A5);
    chk("t1_preg4", 32'(preg[4]), 32'hA5);

    // Round robin with both requesters held; pointer restarts at 0 after reset.
    do_reset();
    @(negedge clk);
    req_addr = {7'h06, 7'h05};
    req_data = {8'h22, 8'h11};
    f0 = mon_frames; g0 = mon_gnts;
    min_gap = 1000;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      c = 0;
      while (gnt == '0 && c < 400) begin @(negedge clk); c++; end
      exp_rr = (k % 2 == 1) ? 2'b10 : 2'b01;
      chk($sformatf("rr_order%0d", k), 32'(gnt), 32'(exp_rr));
      idx = gnt[1] ? 1 : 0;
      $display("rr frame %0d granted req%0d", k, idx);
      req[idx] = 1'b0;
      @(negedge clk);
      if (k > 0 && last_high < min_gap) min_gap = last_high;
      if (k < 2) req[idx] = 1'b1;
    end
    c = 0;
    while (busy && c < 400) begin @(negedge clk); c++; end
    chk("rr_frames", 32'(mon_frames - f0), 32'd4);
    chk("rr_gnts", 32'(mon_gnts - g0), 32'd4);
    chk("rr_multi_gnt", 32'(mon_multi), 32'd0);
    chk("rr_min_gap_ok", 32'(min_gap >= CS_GAP + 1), 32'h1);

    // Peripheral register contents.
    @(negedge clk); periph_clr = 1'b1;
    @(negedge clk); periph_clr = 1'b0;
    do_write(0, 7'h02, 8'h3C, 1'b0);
    do_write(1, 7'h00, 8'hFF, 1'b0);
    chk("p_out_7_0", 32'(preg[0]), 32'hFF);
    chk("p_out_15_8", 32'(preg[1]), 32'h00);
    chk("p_pwm_7_0", 32'(preg[2]), 32'h3C);
    chk("p_pwm_15_8", 32'(preg[3]), 32'h00);
    chk("p_duty", 32'(preg[4]), 32'h00);

    // Reset after the 5th SCLK rise aborts the frame.
    @(negedge clk);
    req_addr[6:0] = 7'h03; req_data[7:0] = 8'h77; req[0] = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!gnt[0] && c < 60);
    chk("abort_gnt", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    d0 = mon_dones;
    prev_sclk = SCLK; r = 0; c = 0;
    while (r < 5 && c < 200) begin
      @(negedge clk); c++;
      if (SCLK && !prev_sclk) r++;
      prev_sclk = SCLK;
    end
    chk("abort_rises_seen", 32'(r), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ncs", 32'(nCS), 32'h1);
    chk("abort_sclk", 32'(SCLK), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(mon_dones - d0), 32'd0);
    chk("abort_preg3", 32'(preg[3]), 32'h00);
    do_write(1, 7'h01, 8'h81, 1'b0);
    chk("after_abort_word", 32'(last_word), 32'h8181);
    chk("after_abort_preg1", 32'(preg[1]), 32'h81);

    // Inputs change right after gnt; frame keeps the captured values.
    do_write(0, 7'h03, 8'h5A, 1'b1);
    chk("latch_word", 32'(last_word), 32'h835A);
    chk("latch_preg3", 32'(preg[3]), 32'h5A);
    chk("latch_preg0", 32'(preg[0]), 32'hFF);

`ifdef SPI_CFG_SHADOW_EN
    f0 = mon_frames;
    do_write(0, 7'h04, 8'h10, 1'b0);
    chk("sh_first_framed", 32'(mon_frames - f0), 32'd1);
    chk("sh_mirror4", 32'(shadow[39:32]), 32'h10);
    f0 = mon_frames;
    do_write(1, 7'h04, 8'h10, 1'b0);
    chk("sh_dup_no_frame", 32'(mon_frames - f0), 32'd0);
    chk("sh_dup_busy_low", 32'(g_busy), 32'h0);
    chk("sh_dup_ncs_high", 32'(g_ncs), 32'h1);
    f0 = mon_frames;
    do_write(0, 7'h05, 8'h00, 1'b0);
    do_write(0, 7'h05, 8'h00, 1'b0);
    chk("sh_addr5_framed", 32'(mon_frames - f0), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
